seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Multiplexed N-digit 7-segment display driver: next generation of the single-digit
//   decoder. Holds a double-buffered BCD/decimal-point frame, time-multiplexes digits with
//   anti-ghost dead time, and supports leading-zero blanking and per-digit blink.
//   Sits between the control logic and the board's shared segment bus plus digit anodes.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned (>=2)
//   REFRESH_DIV  50000  clock cycles per digit slot
//   DEAD_CYC     2      blank cycles at start of each slot (1 <= DEAD_CYC < REFRESH_DIV)
//   BLINK_DIV    64     frames per blink half-period (>=1)
// PORTS
//   iCLK       in   1              system clock
//   iRST       in   1              synchronous reset, active-high
//   iVALUE     in   4*NUM_DIGITS   BCD nibbles; digit k = iVALUE[4k+3:4k]; digit 0 rightmost
//   iDP        in   NUM_DIGITS     decimal point per digit, 1 = lit
//   iLOAD      in   1              1-cycle strobe: capture iVALUE/iDP into pending buffer
//   iBLANK_LZ  in   1              leading-zero blanking enable (live, not buffered)
//   iBLINK     in   NUM_DIGITS     per-digit blink enable (live, not buffered)
//   oSEG       out  8              active-low {dp,g,f,e,d,c,b,a}
//   oAN        out  NUM_DIGITS     active-low digit enables; at most one low at a time
//   oFRAME     out  1              1-cycle pulse when scan wraps from last digit to digit 0
//   oBUSY      out  1              pending buffer not yet transferred to display
// BEHAVIOUR
//   Reset: active/pending buffers 0, prescaler 0, digit index 0, frame/blink counters 0,
//     blink phase = on, oSEG=8'hFF, oAN=all ones, oFRAME=0, oBUSY=0.
//     Reset mid-scan aborts the slot; the next cycle shows reset values.
//   Scan: prescaler counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 and the
//     digit index advances (mod NUM_DIGITS). The wrap NUM_DIGITS-1 -> 0 is a frame end.
//   oSEG/oAN/oFRAME are registered and lag the internal prescaler/index by one cycle.
//     Slot: prescaler < DEAD_CYC -> oAN=all ones, oSEG=FF. Otherwise oAN has only bit[index] low.
//     Frame length = NUM_DIGITS*REFRESH_DIV cycles.
//   Decode (hex): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90.
//     Codes 10..15 -> 7F segments off. The dp bit is still applied.
//     dp: bit7 is cleared when the active iDP bit for the digit is 1.
//   Leading zero: if iBLANK_LZ=1, k>0, and active digits k..NUM_DIGITS-1 are all 0,
//     segments a-g of digit k are off. The dp of that digit still follows its buffer bit.
//     Digit 0 is never LZ-blanked.
//   Blink: the frame counter counts frame ends. After BLINK_DIV of them it clears and blink
//     phase toggles. In the off phase, digits with iBLINK[k]=1 output oSEG=FF including dp.
//     oAN timing is unchanged.
//   Double buffer: iLOAD=1 writes pending buffer and sets oBUSY=1 on the next cycle.
//     A further iLOAD before transfer overwrites pending; the latest value wins.
//     At frame end with oBUSY=1: active <= pending and oBUSY clears on the next cycle.
//     The display never changes mid-frame.
//     iLOAD in the frame-end cycle: the transfer uses the old pending value. The new data
//     enters pending, oBUSY stays 1, and it transfers at the following frame end.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYC=2, BLINK_DIV=2)
//   1 Assert iRST 3 cycles mid-slot -> next cycle oSEG=FF, oAN=1111, oFRAME=0, oBUSY=0.
//     Digit 0 slot restarts after release.
//   2 Load 16'h1234, iDP=4'b0100 -> oBUSY=1 until frame end. Then digit0: oAN=1110, oSEG=99.
//     Digit2: oAN=1011, oSEG=24. Each slot: 2 cycles oAN=1111, then 6 active cycles.
//     oFRAME pulses every 32 cycles.
//   3 iBLANK_LZ=1, load 16'h0070 -> digits3,2 oSEG=FF, digit1 F8, digit0 C0.
//     Load 16'h0000 -> only digit0 lit (C0).
//   4 Load 16'h00A5, iDP=4'b0010 -> digit1 oSEG=7F, digit0 92.
//   5 iBLINK=4'b0001 -> digit0 alternates 2 frames shown / 2 frames FF. Digits 1-3 steady.
//   6 iLOAD 16'h1111 then 16'h2222 in the same frame -> next frame shows 2222.
//     iLOAD in the frame-end cycle -> shown one frame later, oBUSY held 1 across that frame.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver.
// Double-buffered BCD/decimal-point frame, per-slot anti-ghost dead time,
// leading-zero blanking and per-digit blink. All outputs are registered and
// lag the internal prescaler/digit index by one clock.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2,
  parameter int BLINK_DIV   = 64
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iLOAD,
  input  logic                    iBLANK_LZ,
  input  logic [NUM_DIGITS-1:0]   iBLINK,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oFRAME,
  output logic                    oBUSY
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_DIV + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYC);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_DIV - 1);

  // Segment pattern for a BCD code, active-low {g,f,e,d,c,b,a}; non-BCD codes dark.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] digit_q, digit_d;

  // Frame buffers: pending is written by the host, active is what is scanned out
  logic [NUM_DIGITS-1:0][3:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0][3:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]      act_dp_q, act_dp_d;
  logic                       busy_q, busy_d;

  // Blink timing
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_on_q, blink_on_d;

  // Registered display outputs
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  // Combinational helpers
  logic                  slot_end;
  logic                  frame_end;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [6:0]            cur_seg;

  // Next-state logic for scan position, buffers, blink phase and display outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold its value.
    slot_end    = (presc_q == PRESC_LAST);
    frame_end   = slot_end && (digit_q == DIGIT_LAST);
    presc_d     = slot_end ? '0 : presc_q + PW'(1);
    digit_d     = digit_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    upper_zero  = 1'b1;
    lz_mask     = '0;
    cur_seg     = 7'h7F;
    seg_d       = 8'hFF;
    an_d        = '1;
    frame_d     = frame_end;

    if (slot_end) begin
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
    end

    // Frame end swaps in the pending frame (before any same-cycle load lands)
    // and advances the blink timebase.
    if (frame_end) begin
      if (busy_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      busy_d = 1'b0;
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    // A load always wins over the frame-end clear: new data must still transfer.
    if (iLOAD) begin
      pend_val_d = iVALUE;
      pend_dp_d  = iDP;
      busy_d     = 1'b1;
    end

    // Digit k is a leading zero when it and every digit above it are zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (act_val_q[k] == 4'd0);
      lz_mask[k] = iBLANK_LZ && (k != 0) && upper_zero;
    end

    // Outside the dead window, enable the current digit and drive its pattern.
    if (presc_q >= DEAD_END) begin
      an_d[digit_q] = 1'b0;
      cur_seg       = lz_mask[digit_q] ? 7'h7F : dec7(act_val_q[digit_q]);
      seg_d         = {~act_dp_q[digit_q], cur_seg};
      if (!blink_on_q && iBLINK[digit_q]) begin
        seg_d = 8'hFF;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (iRST) begin
      presc_q     <= '0;
      digit_q     <= '0;
      // NOTE: the frame buffers are small register arrays, not RAM, and the
      // display must come up showing zeros, so they are reset explicitly.
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= 8'hFF;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign oSEG   = seg_q;
  assign oAN    = an_q;
  assign oFRAME = frame_q;
  assign oBUSY  = busy_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead
// cycles, blink every 2 frames). Stimulus pushes the expected {anode, segment}
// pair of every slot it cares about; the monitor pops one entry at the start
// of each lit slot and also checks slot shape (dead/active lengths, one-hot
// anode, stability within a slot).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int BD = 2;

  typedef struct {
    logic [ND-1:0] an;
    logic [7:0]    seg;
  } exp_t;

  logic            iCLK = 1'b0;
  logic            iRST = 1'b1;
  logic [4*ND-1:0] iVALUE = '0;
  logic [ND-1:0]   iDP = '0;
  logic            iLOAD = 1'b0;
  logic            iBLANK_LZ = 1'b0;
  logic [ND-1:0]   iBLINK = '0;
  logic [7:0]      oSEG;
  logic [ND-1:0]   oAN;
  logic            oFRAME;
  logic            oBUSY;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYC   (DC),
    .BLINK_DIV  (BD)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iVALUE   (iVALUE),
    .iDP      (iDP),
    .iLOAD    (iLOAD),
    .iBLANK_LZ(iBLANK_LZ),
    .iBLINK   (iBLINK),
    .oSEG     (oSEG),
    .oAN      (oAN),
    .oFRAME   (oFRAME),
    .oBUSY    (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset as seen by the last clock edge, and frame ends counted since reset.
  logic rst_q = 1'b1;
  int   nframes = 0;
  always @(posedge iCLK) begin
    rst_q <= iRST;
    if (iRST) nframes <= 0;
    else if (oFRAME) nframes <= nframes + 1;
  end

  // Monitor: slot shape checks plus scoreboard pop at each slot start.
  int            dead_run = 0;
  int            act_run = 0;
  bit            skip_dead = 1'b1;
  logic [ND-1:0] cur_an;
  logic [7:0]    cur_seg;
  always @(negedge iCLK) begin
    exp_t e;
    if (rst_q) begin
      dead_run  = 0;
      act_run   = 0;
      skip_dead = 1'b1;
    end else if (oAN == '1) begin
      if (act_run != 0) begin
        check("active_len", act_run, RD - DC);
        act_run = 0;
      end
      dead_run++;
    end else begin
      check("an_onehot", $countones(~oAN), 1);
      if (act_run == 0) begin
        if (!skip_dead) check("dead_len", dead_run, DC);
        skip_dead = 1'b0;
        dead_run  = 0;
        cur_an    = oAN;
        cur_seg   = oSEG;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("slot_an", {28'd0, oAN}, {28'd0, e.an});
          check("slot_seg", {24'd0, oSEG}, {24'd0, e.seg});
        end
      end else begin
        check("an_stable", {28'd0, oAN}, {28'd0, cur_an});
        check("seg_stable", {24'd0, oSEG}, {24'd0, cur_seg});
      end
      act_run++;
    end
  end

  // Expected segments for one full frame, digit 0 first.
  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    sb_q.push_back('{an: 4'b1110, seg: s0});
    sb_q.push_back('{an: 4'b1101, seg: s1});
    sb_q.push_back('{an: 4'b1011, seg: s2});
    sb_q.push_back('{an: 4'b0111, seg: s3});
  endtask

  // One-cycle load strobe; returns on the following negedge.
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    iVALUE = v;
    iDP    = dp;
    iLOAD  = 1'b1;
    @(negedge iCLK);
    iLOAD  = 1'b0;
  endtask

  // Wait (bounded) for the next oFRAME pulse; returns cycles waited.
  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge iCLK);
      cyc++;
    end while (!oFRAME && cyc < 200);
    check("frame_seen", {31'd0, oFRAME}, 32'd1);
  endtask

  function automatic bit blink_on(input int k);
    return ((k / BD) % 2) == 0;
  endfunction

  initial begin
    int   n;
    bit   on;
    // Power-on reset
    repeat (3) @(negedge iCLK);
    check("por_seg", {24'd0, oSEG}, 32'hFF);
    check("por_an", {28'd0, oAN}, 32'hF);
    check("por_frame", {31'd0, oFRAME}, 32'd0);
    check("por_busy", {31'd0, oBUSY}, 32'd0);
    iRST = 1'b0;

    // Mid-scan reset aborts the slot and pending load
    do_load(16'h1234, 4'b0100);
    check("busy_set0", {31'd0, oBUSY}, 32'd1);
    repeat (10) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    check("rst_seg", {24'd0, oSEG}, 32'hFF);
    check("rst_an", {28'd0, oAN}, 32'hF);
    check("rst_frame", {31'd0, oFRAME}, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    @(negedge iCLK);
    check("restart_dead0", {28'd0, oAN}, 32'hF);
    @(negedge iCLK);
    check("restart_dead1", {28'd0, oAN}, 32'hF);
    @(negedge iCLK);
    check("restart_d0_an", {28'd0, oAN}, 32'hE);
    check("restart_d0_seg", {24'd0, oSEG}, 32'hC0);

    // Basic decode with a decimal point, double buffering and frame period
    do_load(16'h1234, 4'b0100);
    check("busy_set", {31'd0, oBUSY}, 32'd1);
    wait_frame(n);
    check("busy_clear", {31'd0, oBUSY}, 32'd0);
    push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
    wait_frame(n);
    check("frame_period", n, ND * RD);

    // Leading-zero blanking (live enable)
    iBLANK_LZ = 1'b1;
    push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
    do_load(16'h0070, 4'b0000);
    wait_frame(n);
    push_frame(8'hC0, 8'hF8, 8'hFF, 8'hFF);
    do_load(16'h0000, 4'b0000);
    wait_frame(n);
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Non-BCD code with decimal point
    wait_frame(n);
    iBLANK_LZ = 1'b0;
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    do_load(16'h00A5, 4'b0010);
    wait_frame(n);
    push_frame(8'h92, 8'h7F, 8'hC0, 8'hC0);

    // Blink on digit 0 over four frames, then steady again
    wait_frame(n);
    iBLINK = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_frame(n);
      on = blink_on(nframes + 1);
      push_frame(on ? 8'h92 : 8'hFF, 8'h7F, 8'hC0, 8'hC0);
    end
    wait_frame(n);
    iBLINK = 4'b0000;
    push_frame(8'h92, 8'h7F, 8'hC0, 8'hC0);

    // Back-to-back loads: latest wins
    wait_frame(n);
    push_frame(8'h92, 8'h7F, 8'hC0, 8'hC0);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    check("busy_two_loads", {31'd0, oBUSY}, 32'd1);
    wait_frame(n);
    check("busy_clear2", {31'd0, oBUSY}, 32'd0);
    push_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // Load landing in the frame-end cycle transfers one frame later
    do_load(16'h3333, 4'b0000);
    repeat (30) @(negedge iCLK);
    do_load(16'h4444, 4'b0000);
    check("fe_align", {31'd0, oFRAME}, 32'd1);
    check("fe_busy", {31'd0, oBUSY}, 32'd1);
    push_frame(8'hB0, 8'hB0, 8'hB0, 8'hB0);
    repeat (31) @(negedge iCLK);
    check("fe_busy_held", {31'd0, oBUSY}, 32'd1);
    wait_frame(n);
    check("fe_busy_clear", {31'd0, oBUSY}, 32'd0);
    push_frame(8'h99, 8'h99, 8'h99, 8'h99);
    wait_frame(n);
    repeat (4) @(negedge iCLK);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
